// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: merges N_PORTS AXI-Stream inputs onto one
// output through a one-entry register slice. Each grant is held until the
// granted port's tlast beat is accepted. Output beats carry their source port in m_tid.
module axis_rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           s_tvalid,
    output logic [N_PORTS-1:0]           s_tready,
    input  logic [N_PORTS*DATA_W-1:0]    s_tdata,
    input  logic [N_PORTS*DATA_W/8-1:0]  s_tkeep,
    input  logic [N_PORTS-1:0]           s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic                         m_tlast,
    output logic [ID_W-1:0]              m_tid,
    output logic [ID_W-1:0]              grant_idx,
    output logic                         busy
);
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]     r_grant, w_grant_nxt;
    logic [ID_W-1:0]     w_winner;
    logic                w_found;

    logic                r_m_tvalid;
    logic [DATA_W-1:0]   r_m_tdata;
    logic [KEEP_W-1:0]   r_m_tkeep;
    logic                r_m_tlast;
    logic [ID_W-1:0]     r_m_tid;

    logic                w_out_free;
    logic                w_accept;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;

    // The register slice can take a beat when empty or being drained this cycle
    assign w_out_free  = !r_m_tvalid || m_tready;
    assign w_sel_valid = s_tvalid[r_grant];
    assign w_sel_last  = s_tlast[r_grant];
    assign w_sel_data  = s_tdata[int'(r_grant)*DATA_W +: DATA_W];
    assign w_sel_keep  = s_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
    assign w_accept    = (r_state == ST_LOCKED) && w_sel_valid && w_out_free;

    // Round-robin search: first requesting port starting at r_ptr, wrapping modulo N_PORTS
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!w_found && s_tvalid[(int'(r_ptr) + i) % N_PORTS]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_ptr) + i) % N_PORTS);
            end
        end
    end

    // Only the granted port sees ready; m_tready -> s_tready is the sole combinational path
    always_comb begin
        s_tready = '0;
        if (r_state == ST_LOCKED)
            s_tready[r_grant] = w_out_free;
    end

    // Next-state logic: lock on a winner, release after the tlast beat is accepted
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_winner;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (r_grant == ID_W'(N_PORTS - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Output register slice: load on input accept, otherwise empty when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_data;
            r_m_tkeep  <= w_sel_keep;
            r_m_tlast  <= w_sel_last;
            r_m_tid    <= r_grant;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tvalid  = r_m_tvalid;
    assign m_tdata   = r_m_tdata;
    assign m_tkeep   = r_m_tkeep;
    assign m_tlast   = r_m_tlast;
    assign m_tid     = r_m_tid;
    assign grant_idx = r_grant;
    assign busy      = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: randomized per-port packet sources, a per-cycle
// behavioural model of grant/ready/output, a per-port beat scoreboard,
// and literal expectations for the directed scenarios.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [IW-1:0]     m_tid, grant_idx;
    logic              busy;

    axis_rr_arbiter #(.N_PORTS(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t srcq  [N][$];
    beat_t sentq [N][$];
    bit    cur_v [N];
    int    pause [N];
    int    acc_cnt [N];
    logic [N-1:0] in_acc;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int vprob = 100, rprob = 100;
    bit bp_mode = 0;
    int bp_i = 0;
    int gap_port = -1, gap_at = 0, gap_hold = 0;

    // Behavioural model: who owns the output, rotation pointer, and the output slice
    int    md_owner, md_ptr, md_grant, md_id;
    bit    md_mv;
    beat_t md_out;

    int order[$];
    int mv_times[$];
    bit out_sop = 1;
    int out_id = 0;
    int first_mv = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mdl_reset();
        md_owner = -1; md_ptr = 0; md_grant = 0; md_mv = 0; md_out = '0; md_id = 0;
    endtask

    task automatic add_pkt(input int p, input int len, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? DW'($urandom) : DW'(p * 16 + i);
            b.k = rnd ? KW'($urandom) : '1;
            b.l = (i == len - 1);
            srcq[p].push_back(b);
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (md_owner >= 0 && (!md_mv || m_tready)) exp_rdy[md_owner] = 1'b1;
        chk("s_tready", s_tready, exp_rdy);
        chk("busy", busy, md_owner >= 0);
        chk("grant_idx", grant_idx, md_grant);
        chk("m_tvalid", m_tvalid, md_mv);
        if (md_mv) begin
            chk("m_tdata", m_tdata, md_out.d);
            chk("m_tkeep", m_tkeep, md_out.k);
            chk("m_tlast", m_tlast, md_out.l);
            chk("m_tid", m_tid, md_id);
        end
    endtask

    task automatic scoreboard();
        int id;
        beat_t b;
        if (m_tvalid && first_mv < 0) first_mv = cyc;
        if (!(m_tvalid && m_tready)) return;
        id = int'(m_tid);
        mv_times.push_back(cyc);
        chk("sb_avail", sentq[id].size() > 0, 1);
        if (sentq[id].size() > 0) begin
            b = sentq[id].pop_front();
            chk("sb_data", m_tdata, b.d);
            chk("sb_keep", m_tkeep, b.k);
            chk("sb_last", m_tlast, b.l);
        end
        if (out_sop) begin
            order.push_back(id);
            out_id = id;
        end else begin
            chk("contiguous", id, out_id);
        end
        out_sop = m_tlast;
    endtask

    // Advance the model across one rising edge using the inputs seen this cycle
    task automatic model_update();
        bit acc;
        acc = 0;
        if (md_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (md_owner < 0 && s_tvalid[(md_ptr + i) % N]) begin
                    md_owner = (md_ptr + i) % N;
                    md_grant = md_owner;
                end
            end
        end else if ((!md_mv || m_tready) && s_tvalid[md_owner]) begin
            acc = 1;
            md_out.d = s_tdata[md_owner*DW +: DW];
            md_out.k = s_tkeep[md_owner*KW +: KW];
            md_out.l = s_tlast[md_owner];
            md_mv = 1;
            md_id = md_owner;
            if (md_out.l) begin
                md_ptr = (md_owner + 1) % N;
                md_owner = -1;
            end
        end
        if (!acc && m_tready) md_mv = 0;
    endtask

    task automatic drive();
        beat_t b;
        for (int p = 0; p < N; p++) begin
            if (in_acc[p]) begin
                b = srcq[p].pop_front();
                sentq[p].push_back(b);
                acc_cnt[p]++;
                cur_v[p] = 0;
                if (p == gap_port && acc_cnt[p] == gap_at) pause[p] = 5;
            end
            if (pause[p] > 0) begin
                pause[p]--;
                cur_v[p] = 0;
            end else if (!cur_v[p] && srcq[p].size() > 0 && $urandom_range(99) < vprob) begin
                cur_v[p] = 1;
            end
            s_tvalid[p] = cur_v[p];
            if (cur_v[p]) begin
                s_tdata[p*DW +: DW] = srcq[p][0].d;
                s_tkeep[p*KW +: KW] = srcq[p][0].k;
                s_tlast[p]          = srcq[p][0].l;
            end else begin
                s_tdata[p*DW +: DW] = DW'($urandom);
                s_tkeep[p*KW +: KW] = KW'($urandom);
                s_tlast[p]          = 1'($urandom);
            end
        end
        if (bp_mode) begin
            m_tready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
            bp_i++;
        end else begin
            m_tready = ($urandom_range(99) < rprob);
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        scoreboard();
        if (gap_port >= 0 && !s_tvalid[gap_port] && busy && int'(grant_idx) == gap_port && s_tvalid[0])
            gap_hold++;
        in_acc = s_tvalid & s_tready;
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        drive();
    endtask

    function automatic bit work_left();
        bit w;
        w = (md_owner >= 0) || md_mv;
        for (int p = 0; p < N; p++) if (srcq[p].size() > 0 || cur_v[p]) w = 1;
        return w;
    endfunction

    task automatic drain(input string nm, input int maxc);
        int n, left;
        n = 0;
        while (work_left() && n < maxc) begin
            step();
            n++;
        end
        chk({nm, "_timeout"}, n < maxc, 1);
        left = 0;
        for (int p = 0; p < N; p++) left += sentq[p].size();
        chk({nm, "_sb_drained"}, left, 0);
    endtask

    task automatic clear_all();
        for (int p = 0; p < N; p++) begin
            srcq[p].delete(); sentq[p].delete();
            cur_v[p] = 0; pause[p] = 0; acc_cnt[p] = 0;
        end
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        in_acc = '0; out_sop = 1;
    endtask

    initial begin
        int t0, n;
        rst = 1'b1;
        m_tready = 1'b1;
        clear_all();
        mdl_reset();
        @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tid", m_tid, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Rotation: all ports valid, 3-beat packets, port 0 has two packets
        for (int p = 0; p < N; p++) add_pkt(p, 3, 0);
        add_pkt(0, 3, 0);
        order.delete();
        first_mv = -1;
        t0 = cyc + 1;
        drain("rotation", 200);
        chk("first_beat_latency", first_mv - t0, 2);
        chk("rot_count", order.size(), 5);
        if (order.size() == 5) begin
            chk("rot_0", order[0], 0); chk("rot_1", order[1], 1);
            chk("rot_2", order[2], 2); chk("rot_3", order[3], 3);
            chk("rot_4", order[4], 0);
        end

        // Wrap/skip: move pointer to 2 via a port-1 packet, then only ports 1 and 3 request
        add_pkt(1, 2, 1);
        drain("ptr_setup", 100);
        order.delete();
        add_pkt(3, 2, 1); add_pkt(3, 3, 1); add_pkt(1, 2, 1);
        drain("wrap", 200);
        chk("wrap_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("wrap_0", order[0], 3); chk("wrap_1", order[1], 1); chk("wrap_2", order[2], 3);
        end

        // Backpressure: m_tready cycles 1,0,0,1 across an 8-beat packet
        bp_mode = 1; bp_i = 0;
        for (int p = 0; p < N; p++) acc_cnt[p] = 0;
        order.delete();
        add_pkt(0, 8, 1);
        drain("backpressure", 200);
        bp_mode = 0;
        chk("bp_beats_in", acc_cnt[0], 8);
        chk("bp_packets", order.size(), 1);

        // Mid-packet gap: port 2 pauses 5 cycles after beat 2 while port 0 waits
        for (int p = 0; p < N; p++) acc_cnt[p] = 0;
        order.delete();
        gap_port = 2; gap_at = 2; gap_hold = 0;
        add_pkt(2, 6, 1);
        step(); step();
        add_pkt(0, 3, 1);
        drain("midgap", 200);
        chk("gap_hold_cycles", gap_hold, 5);
        gap_port = -1;
        chk("gap_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("gap_first", order[0], 2); chk("gap_second", order[1], 0);
        end

        // Single requester: port 3 back-to-back 1-beat packets, output every other cycle
        order.delete(); mv_times.delete();
        for (int i = 0; i < 6; i++) add_pkt(3, 1, 1);
        drain("single", 200);
        chk("single_count", mv_times.size(), 6);
        for (int i = 1; i < mv_times.size(); i++) chk("single_spacing", mv_times[i] - mv_times[i-1], 2);
        for (int i = 0; i < order.size(); i++) chk("single_port", order[i], 3);

        // Randomized traffic with random valid gaps and backpressure
        vprob = 70; rprob = 60;
        for (int i = 0; i < 150; i++) add_pkt($urandom_range(N-1), $urandom_range(1, 6), 1);
        drain("random", 20000);
        vprob = 100; rprob = 100;
        drain("settle", 50);

        // Reset mid-packet: assert between edges while port 1's beat 3 is on the bus
        for (int p = 0; p < N; p++) acc_cnt[p] = 0;
        add_pkt(1, 6, 1);
        n = 0;
        while (acc_cnt[1] < 2 && n < 50) begin step(); n++; end
        chk("pre_reset_progress", acc_cnt[1], 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_m_tvalid", m_tvalid, 0);
        chk("arst_s_tready", s_tready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_grant", grant_idx, 0);
        clear_all();
        mdl_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        order.delete();
        add_pkt(2, 2, 1); add_pkt(1, 2, 1); add_pkt(0, 2, 1);
        drain("post_reset", 200);
        chk("post_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("post_0", order[0], 0); chk("post_1", order[1], 1); chk("post_2", order[2], 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-aware round-robin arbiter that merges `N_PORTS` AXI-Stream slave inputs onto one AXI-Stream master output. It sits between several stream producers and a single shared stream consumer, such as a DMA write channel or an AXI-Lite/AXI bridge. Grants are held for a whole packet, up to and including the `tlast` beat. The output passes through a one-entry register slice, and each output beat is tagged with its source port index.

## Interface
Parameters:
- `N_PORTS`, default 4: number of slave inputs; legal range 2..16.
- `DATA_W`, default 32: tdata width; must be a multiple of 8.
- `ID_W`, default `$clog2(N_PORTS)`: width of `m_tid` and `grant_idx`.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_tvalid` in `N_PORTS`: per-port valid.
- `s_tready` out `N_PORTS`: per-port ready; at most one bit is high at any time.
- `s_tdata` in `N_PORTS*DATA_W`: port p occupies bits `[p*DATA_W +: DATA_W]`.
- `s_tkeep` in `N_PORTS*DATA_W/8`: per-port byte enables.
- `s_tlast` in `N_PORTS`: per-port end of packet.
- `m_tvalid` out 1; `m_tready` in 1.
- `m_tdata` out `DATA_W`; `m_tkeep` out `DATA_W/8`; `m_tlast` out 1.
- `m_tid` out `ID_W`: index of the source port of the current output beat.
- `grant_idx` out `ID_W`: currently or last granted port.
- `busy` out 1: high while in LOCKED.

## Operation
- FSM with two states.
  - **IDLE**: no port granted; all `s_tready` = 0.
  - **LOCKED**: port `grant_idx` owns the output.
- Round-robin pointer `ptr` (`ID_W` bits) holds the highest-priority port.
- IDLE behaviour, when any `s_tvalid` is high:
  - Winner = first p with `s_tvalid[p]`, searching `ptr`, `ptr+1`, … , `N_PORTS-1`, 0, … (search wraps modulo `N_PORTS`).
  - On the next edge: `grant_idx` = winner, state = LOCKED.
  - Non-requesting ports are skipped; with no valid inputs, the FSM stays in IDLE.
- LOCKED behaviour:
  - `s_tready[grant_idx] = !m_tvalid || m_tready`; all other bits are 0.
  - An accepted beat loads `s_tdata`/`s_tkeep`/`s_tlast` of `grant_idx` into the output register and sets `m_tid = grant_idx`.
  - An accepted beat with `s_tlast` = 1: next state IDLE, `ptr` = (`grant_idx`+1) mod `N_PORTS`.
    - Wrap case: `grant_idx` = `N_PORTS-1` gives `ptr` = 0.
  - If the granted port drops `s_tvalid` mid-packet, the grant is held indefinitely (no timeout, no pre-emption).
- Output register slice:
  - `m_tvalid` is set on an accepted input beat.
  - `m_tvalid` is cleared on `m_tready` when no new beat is accepted in the same cycle.
  - Output accept and input accept in the same cycle replace the register contents (full throughput).
  - `m_*` must hold stable while `m_tvalid && !m_tready`.
- `s_tvalid` on ports that are not granted is ignored; their data is never sampled.
- `busy` = (state == LOCKED).
- Reset (asynchronous, at any time, including mid-packet):
  - State = IDLE; `ptr` = 0; `grant_idx` = 0.
  - `m_tvalid`, `m_tlast` = 0; `m_tdata`, `m_tkeep`, `m_tid` = 0.
  - `busy` = 0; `s_tready` = all 0.
  - A partial packet in flight is dropped; the bench must not expect its remainder.

## Timing
- Arbitration: `s_tvalid[p]` first high in cycle 0 while IDLE → LOCKED from cycle 1 → `s_tready[p]` high in cycle 1 (output register empty) → first beat on `m_*` in cycle 2.
- Within a packet: 1 beat per cycle while `m_tready` = 1. Latency from `s_tvalid && s_tready` to `m_tvalid` is 1 cycle.
- Packet gap:
  - The `tlast` beat is accepted in cycle n; IDLE in cycle n+1; the next grant is effective in cycle n+2.
  - Result: one dead input cycle between packets, so single-beat packets reach at most 50% throughput.
- Combinational paths:
  - `m_tready` → `s_tready` is the only combinational path.
  - `m_*`, `grant_idx`, `busy` are all registered.

## Test plan
- **Rotation**: all 4 ports continuously valid with 3-beat packets (port p data = 0xP0..0xP2), `m_tready` = 1.
  - Output sequence: ports 0,1,2,3,0, each packet contiguous, `m_tid` matches port.
  - One dead input cycle between packets.
- **Wrap/skip**: only ports 1 and 3 valid, `ptr` = 2.
  - Port 3 granted first, then port 1, then 3.
  - No grant ever given to ports 0 or 2.
- **Backpressure**: `m_tready` toggles 1,0,0,1 during an 8-beat packet.
  - All 8 beats arrive in order with no duplication or loss.
  - `m_*` stable while stalled; `s_tready` = 0 during stall cycles with `m_tvalid` = 1.
- **Mid-packet gap**: granted port 2 drops `s_tvalid` for 5 cycles after beat 2 while port 0 is requesting.
  - `grant_idx` stays 2 and `busy` stays 1.
  - Port 0 is served only after port 2's `tlast`.
- **Reset mid-packet**: assert `rst` asynchronously between edges during beat 3 of a port-1 packet.
  - Outputs go to reset values immediately (`m_tvalid` = 0, `s_tready` = 0).
  - After release, port 0 has priority (`ptr` = 0).
- **Single requester**: port 3 only, 1-beat packets back-to-back.
  - Grant on every packet, `m_tvalid` high every other cycle.
  - `ptr` wraps to 0 after each packet.
